wb_pipe_unit: RTL
=================

WB_PIPE_UNIT -- requirements
Module: wb_pipe_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning datapath width.
REQ-002 SHALL have parameter NUM_SRC, default 3, meaning number of synchronous-read memory sources.
REQ-003 SHALL have parameter REGION_MAP, default {4'b0011,4'b0001,4'b0100}, meaning packed 4-bit address-region ID per source, source 0 in LSBs.
REQ-004 SHALL have parameter PC_INC, default 4, meaning link-address increment.
REQ-005 SHALL have port clk, input, 1, meaning the single clock; reset is asynchronous and active-low.
REQ-006 SHALL have port rst_n, input, 1, meaning asynchronous active-low reset.
REQ-007 SHALL have ports stall, flush and in_valid, each input, 1, meaning hold the stage, kill the stage and incoming instruction valid.
REQ-008 SHALL have port in_wb_sel, input, 2, meaning 0 ALU, 1 MEM, 2 PC+PC_INC, 3 reserved (treated as ALU).
REQ-009 SHALL have ports in_pc and in_alu, each input, XLEN, meaning instruction PC and ALU result/load address.
REQ-010 SHALL have ports in_rd (input, 5), in_reg_we (input, 1) and in_funct3 (input, 3), meaning destination, write intent and load type.
REQ-011 SHALL have port mem_dout, input, NUM_SRC*XLEN, meaning per-source read data, valid the cycle after address issue.
REQ-012 SHALL have ports rf_we (output, 1), rf_waddr (output, 5) and rf_wdata (output, XLEN), meaning register-file write.
REQ-013 SHALL have ports misalign and region_miss, each output, 1, meaning one-cycle fault pulses.
REQ-014 SHALL have port miss_count, output, 8, meaning saturating fault counter.

Function
REQ-015 SHALL capture in_* into stage registers on a rising edge when stall=0; stage valid = in_valid & ~flush.
REQ-016 SHALL clear stage valid on any edge with flush=1; flush overrides stall.
REQ-017 SHALL hold stage registers unchanged while stall=0 is false and flush=0.
REQ-018 SHALL produce rf_* combinationally from stage registers: one-cycle latency from capture.
REQ-019 SHALL select the load source as the lowest index i whose REGION_MAP ID equals stage alu[XLEN-1:XLEN-4].
REQ-020 SHALL, on the first stalled cycle of a valid MEM-stage instruction, latch the selected mem_dout into a hold register and set hold_vld; subsequent stalled cycles and the release cycle SHALL use held data.
REQ-021 SHALL clear hold_vld on the edge that advances or flushes the stage.
REQ-022 SHALL extract load data by funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU, using alu[1:0] as byte lane; sign- or zero-extend to XLEN; other funct3 values behave as LW.
REQ-023 SHALL set rf_wdata = stage alu for wb_sel 0/3, and stage pc+PC_INC (mod 2^XLEN) for wb_sel 2.
REQ-024 SHALL assert rf_we = valid & reg_we & (rd!=0) & ~stall & ~fault; fault = region_miss | misalign.
REQ-025 SHALL flag misalign for a valid MEM load when LH/LHU has alu[0]=1 or LW has alu[1:0]!=0.
REQ-026 SHALL flag region_miss for a valid MEM load matching no REGION_MAP entry, with rf_wdata=0.
REQ-027 SHALL pulse fault outputs only in the non-stalled cycle in which the stage retires.
REQ-028 SHALL increment miss_count on each fault pulse and saturate at 255.

Reset
REQ-029 SHALL, on rst_n low, asynchronously clear stage valid, hold_vld, all stage registers and miss_count; rf_we, misalign and region_miss SHALL read 0 and rf_wdata 0.
REQ-030 SHALL drop any in-flight instruction on reset mid-operation, with no write after release.

Structure
REQ-031 SHALL place wb_sel encodings, funct3 load encodings and region-ID constants in shared package riscv_wb_pkg.
REQ-032 SHALL implement byte/half extraction as sub-module load_extract (combinational, XLEN-parametrised).

Verification
REQ-033 SHALL cover: LB with alu=0x1000_0003 and dmem word 0x80FF_1234 -> rf_wdata=0xFFFF_FF80 one cycle later.
REQ-034 SHALL cover: LHU with alu=0x4000_0002 and BIOS word 0xBEEF_0000 -> rf_wdata=0x0000_BEEF from source 0.
REQ-035 SHALL cover: LW issued and then stall held 3 cycles while mem_dout changes to 0xDEAD_DEAD -> the original word is written once, on release.
REQ-036 SHALL cover: JAL with pc=0xFFFF_FFFC and wb_sel=2 -> rf_wdata=0x0000_0000, rd=1 written.
REQ-037 SHALL cover: LW with alu=0x2000_0000 (no region) -> region_miss pulse, rf_we=0, miss_count=1; repeat 300 faults -> miss_count=255.
REQ-038 SHALL cover: flush and stall asserted together, then a write with rd=0 and rst_n pulsed mid-stall -> no rf_we in all three cases.

Source files
------------

// File: rtl/riscv_wb_pkg.sv
// riscv_wb_pkg: shared write-back select, load funct3 and address-region encodings
package riscv_wb_pkg;
  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC  = 2'd2;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [3:0] REGION_DMEM = 4'h1;
  localparam logic [3:0] REGION_IO   = 4'h3;
  localparam logic [3:0] REGION_BIOS = 4'h4;
endpackage

// File: rtl/load_extract.sv
// load_extract: picks the byte/half lane of a loaded word and sign- or zero-extends it
module load_extract
  import riscv_wb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] word_i,
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      lane_i,
  output logic [XLEN-1:0] data_o
);
  logic [7:0]  b;
  logic [15:0] h;
  assign b = word_i[8*lane_i +: 8];
  assign h = lane_i[1] ? word_i[31:16] : word_i[15:0];
  // unknown funct3 values fall through to a full-word load
  always_comb
    data_o = (funct3_i == F3_LB)  ? {{(XLEN-8){b[7]}}, b} :
             (funct3_i == F3_LBU) ? {{(XLEN-8){1'b0}}, b} :
             (funct3_i == F3_LH)  ? {{(XLEN-16){h[15]}}, h} :
             (funct3_i == F3_LHU) ? {{(XLEN-16){1'b0}}, h} : word_i;
endmodule

// File: rtl/wb_pipe_unit.sv
// wb_pipe_unit: write-back stage with region-mapped load sources, stall hold buffer and fault counter
module wb_pipe_unit
  import riscv_wb_pkg::*;
#(
  parameter int                   XLEN       = 32,
  parameter int                   NUM_SRC    = 3,
  parameter logic [4*NUM_SRC-1:0] REGION_MAP = {REGION_IO, REGION_DMEM, REGION_BIOS},
  parameter int                   PC_INC     = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    stall,
  input  logic                    flush,
  input  logic                    in_valid,
  input  logic [1:0]              in_wb_sel,
  input  logic [XLEN-1:0]         in_pc,
  input  logic [XLEN-1:0]         in_alu,
  input  logic [4:0]              in_rd,
  input  logic                    in_reg_we,
  input  logic [2:0]              in_funct3,
  input  logic [NUM_SRC*XLEN-1:0] mem_dout,
  output logic                    rf_we,
  output logic [4:0]              rf_waddr,
  output logic [XLEN-1:0]         rf_wdata,
  output logic                    misalign,
  output logic                    region_miss,
  output logic [7:0]              miss_count
);
  logic            valid_q, reg_we_q, hold_vld_q, hold_vld_d;
  logic [1:0]      wb_sel_q;
  logic [XLEN-1:0] pc_q, alu_q, hold_q, hold_d, src_word, mem_word, ld_data;
  logic [4:0]      rd_q;
  logic [2:0]      funct3_q;
  logic [7:0]      miss_d;
  logic            is_mem, hit, mis_raw, retire, fault;
  // lowest-index source whose region ID matches the top nibble of the address wins
  always_comb begin
    hit = 1'b0;
    src_word = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--)
      if (REGION_MAP[4*i +: 4] == alu_q[XLEN-1 -: 4]) begin
        hit = 1'b1;
        src_word = mem_dout[XLEN*i +: XLEN];
      end
  end
  assign mem_word = hold_vld_q ? hold_q : src_word;
  load_extract #(.XLEN(XLEN)) u_ext (
    .word_i   (mem_word),
    .funct3_i (funct3_q),
    .lane_i   (alu_q[1:0]),
    .data_o   (ld_data)
  );
  // faults only surface in the cycle the stage actually retires
  always_comb begin
    is_mem      = valid_q && wb_sel_q == WB_MEM;
    mis_raw     = ((funct3_q == F3_LH || funct3_q == F3_LHU) && alu_q[0]) ||
                  (funct3_q == F3_LW && alu_q[1:0] != 2'b00);
    retire      = is_mem && !stall;
    misalign    = retire && mis_raw;
    region_miss = retire && !hit;
    fault       = misalign || region_miss;
    rf_we       = valid_q && !stall && reg_we_q && rd_q != 5'd0 && !fault;
    rf_waddr    = rd_q;
    rf_wdata    = (wb_sel_q == WB_MEM) ? (hit ? ld_data : '0) :
                  (wb_sel_q == WB_PC)  ? pc_q + XLEN'(PC_INC) : alu_q;
    hold_d      = (is_mem && stall && !flush && !hold_vld_q) ? src_word : hold_q;
    hold_vld_d  = !flush && stall && (hold_vld_q || is_mem);
    miss_d      = (fault && miss_count != 8'hFF) ? miss_count + 8'd1 : miss_count;
  end
  // stage registers: flush kills, stall holds, otherwise capture the incoming instruction
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      valid_q    <= 1'b0;
      wb_sel_q   <= '0;
      pc_q       <= '0;
      alu_q      <= '0;
      rd_q       <= '0;
      reg_we_q   <= 1'b0;
      funct3_q   <= '0;
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
      miss_count <= '0;
    end else begin
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      miss_count <= miss_d;
      if (flush) valid_q <= 1'b0;
      else if (!stall) begin
        valid_q  <= in_valid;
        wb_sel_q <= in_wb_sel;
        pc_q     <= in_pc;
        alu_q    <= in_alu;
        rd_q     <= in_rd;
        reg_we_q <= in_reg_we;
        funct3_q <= in_funct3;
      end
    end
endmodule
